// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: state encodings, owner codes,
// loader PC marker and small address helpers.
package dm_arb_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_C = 2'd1;
  localparam logic [1:0] SERVE_L = 2'd2;

  localparam logic OWNER_C = 1'b0;
  localparam logic OWNER_L = 1'b1;

  localparam logic [31:0] LOADER_PC = 32'hFFFF_FFFF;

  // Wide enough for the largest allowed C weight (15).
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } dm_access_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic addr_in_range(input logic [31:0] a, input logic [32:0] limit);
    return {1'b0, a} < limit;
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner select between the C and L candidates: weighted alternation
// when both are pending, otherwise whichever one is requesting.
module dm_arb_pick
  import dm_arb_pkg::*;
#(
  parameter int unsigned C_WEIGHT = 4
) (
  input  logic             i_c_req,
  input  logic             i_l_req,
  input  logic             i_last_grant,
  input  logic [CNT_W-1:0] i_c_cnt,
  output logic             o_grant_vld,
  output logic             o_grant_owner
);

  always_comb begin
    o_grant_vld   = i_c_req | i_l_req;
    o_grant_owner = OWNER_C;
    if (i_c_req && i_l_req) begin
      // Weight exhausted forces L; otherwise take turns against the previous grant.
      if (i_c_cnt == CNT_W'(C_WEIGHT)) begin
        o_grant_owner = OWNER_L;
      end else if (i_last_grant == OWNER_C) begin
        o_grant_owner = OWNER_L;
      end else begin
        o_grant_owner = OWNER_C;
      end
    end else if (i_l_req) begin
      o_grant_owner = OWNER_L;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter between the MEM stage (C) and the loader (L).
// Optional write/error trace enabled by defining DM_ARB_TRACE_EN.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned C_WEIGHT   = 4,
  parameter int unsigned ADDR_WORDS = 32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [31:0] c_pc,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_ack,
  output logic [31:0] l_rdata,
  output logic        l_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] ADDR_LIMIT = 33'(ADDR_WORDS) << 2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_c_cnt;
  logic [CNT_W-1:0] w_c_cnt_nxt;
  logic [31:0]      r_addr_hold;
  logic [31:0]      r_wdata_hold;
  logic [31:0]      r_pc_hold;

  logic       w_serve_c;
  logic       w_serve_l;
  logic       w_c_inr;
  logic       w_l_inr;
  logic       w_c_cand;
  logic       w_l_cand;
  logic       w_grant_vld;
  logic       w_grant_owner;
  logic       w_acc_inr;
  dm_access_t w_acc;

  // Reset low suppresses the serve of the current cycle: no ack, no write.
  assign w_serve_c = reset && (r_state == SERVE_C);
  assign w_serve_l = reset && (r_state == SERVE_L);

  assign w_c_inr = addr_in_range(c_addr, ADDR_LIMIT);
  assign w_l_inr = addr_in_range(l_addr, ADDR_LIMIT);

  // The request being served this cycle is consumed; a still-high req is a new access next cycle.
  assign w_c_cand = c_req && (r_state != SERVE_C);
  assign w_l_cand = l_req && (r_state != SERVE_L);

  dm_arb_pick #(
    .C_WEIGHT (C_WEIGHT)
  ) u_pick (
    .i_c_req       (w_c_cand),
    .i_l_req       (w_l_cand),
    .i_last_grant  (r_last_grant),
    .i_c_cnt       (r_c_cnt),
    .o_grant_vld   (w_grant_vld),
    .o_grant_owner (w_grant_owner)
  );

  always_comb begin
    w_state_nxt = IDLE;
    if (w_grant_vld) begin
      w_state_nxt = (w_grant_owner == OWNER_C) ? SERVE_C : SERVE_L;
    end
  end

  always_comb begin
    w_c_cnt_nxt = r_c_cnt;
    if (!l_req) begin
      w_c_cnt_nxt = '0;
    end else if (w_grant_vld) begin
      if (w_grant_owner == OWNER_L) begin
        w_c_cnt_nxt = '0;
      end else if (r_c_cnt != CNT_W'(C_WEIGHT)) begin
        w_c_cnt_nxt = r_c_cnt + CNT_W'(1);
      end
    end
  end

  // Outside a serve the DM address/data/pc hold their last values.
  always_comb begin
    w_acc     = '{we: 1'b0, addr: r_addr_hold, wdata: r_wdata_hold, pc: r_pc_hold};
    w_acc_inr = 1'b0;
    if (w_serve_c) begin
      w_acc     = '{we: c_we, addr: word_align(c_addr), wdata: c_wdata, pc: c_pc};
      w_acc_inr = w_c_inr;
    end else if (w_serve_l) begin
      w_acc     = '{we: l_we, addr: word_align(l_addr), wdata: l_wdata, pc: LOADER_PC};
      w_acc_inr = w_l_inr;
    end
  end

  assign mem_we    = w_acc.we & w_acc_inr;
  assign mem_addr  = w_acc.addr;
  assign mem_wdata = w_acc.wdata;
  assign mem_pc    = w_acc.pc;

  assign c_ack   = w_serve_c;
  assign c_err   = w_serve_c & ~w_c_inr;
  assign c_rdata = (w_serve_c && w_c_inr) ? mem_rdata : '0;

  assign l_ack   = w_serve_l;
  assign l_err   = w_serve_l & ~w_l_inr;
  assign l_rdata = (w_serve_l && w_l_inr) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last_grant <= OWNER_L;
      r_c_cnt      <= '0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
      r_pc_hold    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_c_cnt <= w_c_cnt_nxt;
      if (w_grant_vld) begin
        r_last_grant <= w_grant_owner;
      end
      if (w_serve_c || w_serve_l) begin
        r_addr_hold  <= w_acc.addr;
        r_wdata_hold <= w_acc.wdata;
        r_pc_hold    <= w_acc.pc;
      end
    end
  end

`ifdef DM_ARB_TRACE_EN
  always_ff @(posedge clk) begin
    if (mem_we) begin
      $display("%d@%h: *%h <= %h", $time, mem_pc, mem_addr, mem_wdata);
    end
    if (c_err || l_err) begin
      $display("ARB ERR %h", mem_addr);
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios plus randomized two-port traffic,
// all checked cycle by cycle against a transaction-level reference model and shadow memory.
module tb_dm_port_arbiter;

  localparam int unsigned C_WEIGHT   = 4;
  localparam int unsigned ADDR_WORDS = 32768;
  localparam logic [31:0] LPC        = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0, c_pc = '0;
  logic        l_req = 1'b0, l_we = 1'b0;
  logic [31:0] l_addr = '0, l_wdata = '0;
  logic        c_ack, c_err, l_ack, l_err, mem_we;
  logic [31:0] c_rdata, l_rdata, mem_addr, mem_wdata, mem_pc, mem_rdata;

  logic [31:0] dm     [ADDR_WORDS];
  logic [31:0] shadow [ADDR_WORDS];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(
    .C_WEIGHT   (C_WEIGHT),
    .ADDR_WORDS (ADDR_WORDS)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_pc      (c_pc),
    .c_ack     (c_ack),
    .c_rdata   (c_rdata),
    .c_err     (c_err),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_ack     (l_ack),
    .l_rdata   (l_rdata),
    .l_err     (l_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_pc    (mem_pc),
    .mem_rdata (mem_rdata)
  );

  // Behavioural DM: combinational read, write on posedge.
  assign mem_rdata = dm[mem_addr[16:2]];
  always @(posedge clk) begin
    if (mem_we) dm[mem_addr[16:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who is served this cycle, last grant, consecutive-C counter, held DM bus.
  bit          mon_en = 1'b0;
  int          m_serve = 0;          // 0 none, 1 C, 2 L
  bit          m_last_l = 1'b1;
  int unsigned m_cnt = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_pc = '0;
  bit          m_c_acked = 1'b0, m_l_acked = 1'b0;

  always @(negedge clk) begin : monitor
    bit          sc, sl, inr, ewe, cc, lc, win_any, win_c;
    logic [31:0] a, w, p, rd;
    if (mon_en) begin
      sc  = rst_n && (m_serve == 1);
      sl  = rst_n && (m_serve == 2);
      a   = sc ? c_addr : l_addr;
      w   = sc ? c_wdata : l_wdata;
      p   = sc ? c_pc : LPC;
      inr = a < ADDR_WORDS * 4;
      ewe = (sc || sl) && (sc ? c_we : l_we) && inr;
      rd  = inr ? shadow[a[16:2]] : 32'h0;
      if (sc || sl) begin
        m_addr  = {a[31:2], 2'b00};
        m_wdata = w;
        m_pc    = p;
      end
      chk("c_ack", 32'(c_ack), 32'(sc));
      chk("l_ack", 32'(l_ack), 32'(sl));
      chk("c_err", 32'(c_err), 32'(sc && !inr));
      chk("l_err", 32'(l_err), 32'(sl && !inr));
      chk("c_rdata", c_rdata, sc ? rd : 32'h0);
      chk("l_rdata", l_rdata, sl ? rd : 32'h0);
      chk("mem_we", 32'(mem_we), 32'(ewe));
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_pc", mem_pc, m_pc);
      if (ewe) shadow[a[16:2]] = w;
      m_c_acked = sc;
      m_l_acked = sl;
      if (!rst_n) begin
        m_serve = 0; m_last_l = 1'b1; m_cnt = 0;
        m_addr = '0; m_wdata = '0; m_pc = '0;
      end else begin
        cc      = c_req && (m_serve != 1);
        lc      = l_req && (m_serve != 2);
        win_any = cc || lc;
        if (cc && lc) win_c = (m_cnt == C_WEIGHT) ? 1'b0 : m_last_l;
        else          win_c = cc;
        if (!l_req)       m_cnt = 0;
        else if (win_any) m_cnt = win_c ? ((m_cnt < C_WEIGHT) ? m_cnt + 1 : m_cnt) : 0;
        if (win_any) m_last_l = !win_c;
        m_serve = !win_any ? 0 : (win_c ? 1 : 2);
      end
    end
  end

  task automatic xfer(input bit is_l, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] pc,
                      output logic [31:0] rdata, output logic err, output logic we_seen,
                      output int lat);
    bit got = 1'b0;
    if (is_l) begin l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata; end
    else begin c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; c_pc = pc; end
    rdata = '0; err = 1'b0; we_seen = 1'b0; lat = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      if (is_l ? l_ack : c_ack) begin
        got = 1'b1; lat = i; we_seen = mem_we;
        rdata = is_l ? l_rdata : c_rdata;
        err = is_l ? l_err : c_err;
      end
    end
    chk(is_l ? "l_xfer_ack" : "c_xfer_ack", 32'(got), 32'd1);
    @(posedge clk); #1;
    if (is_l) l_req = 1'b0; else c_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r = $urandom;
    if (r[3:0] == 4'd0) return 32'h0002_0000 | ($urandom & 32'h7FFF_FFFF);
    return {24'd0, r[9:4], r[11:10]};
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] rd;
    logic        er, ws;
    int          lat, n_c, n_l, viol, both, prev, waitc;
    bit          got;

    for (int i = 0; i < int'(ADDR_WORDS); i++) begin
      dm[i] = '0;
      shadow[i] = '0;
    end

    // 1: reset held two cycles, nothing requested
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_c_ack", 32'(c_ack), 32'd0);
    chk("t1_l_ack", 32'(l_ack), 32'd0);
    chk("t1_mem_we", 32'(mem_we), 32'd0);
    chk("t1_mem_pc", mem_pc, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2: C write then read back, one-cycle grant latency from IDLE
    xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h100, rd, er, ws, lat);
    chk("t2_wr_latency", 32'(lat), 32'd2);
    chk("t2_wr_we", 32'(ws), 32'd1);
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 32'h104, rd, er, ws, lat);
    chk("t2_rd_data", rd, 32'hDEADBEEF);
    chk("t2_rd_we", 32'(ws), 32'd0);

    // 5: loader write beyond DM depth aliases word 0 but must not write
    xfer(1'b0, 1'b1, 32'h0, 32'h12345678, 32'h108, rd, er, ws, lat);
    xfer(1'b1, 1'b1, 32'h0002_0000, 32'hCAFEF00D, 32'h0, rd, er, ws, lat);
    chk("t5_l_err", 32'(er), 32'd1);
    chk("t5_mem_we", 32'(ws), 32'd0);
    @(negedge clk);
    chk("t5_dm0", dm[0], 32'h12345678);
    @(posedge clk); #1;

    // 3: both requesting continuously -> strict alternation
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h0;
    n_c = 0; n_l = 0; viol = 0; both = 0; prev = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (c_ack && l_ack) both++;
      if (c_ack) begin n_c++; if (prev == 1) viol++; prev = 1; end
      if (l_ack) begin n_l++; if (prev == 2) viol++; prev = 2; end
    end
    chk("t3_double_ack", 32'(both), 32'd0);
    chk("t3_runs", 32'(viol), 32'd0);
    chk("t3_total", 32'(n_c + n_l), 32'd19);
    chk("t3_c_count", 32'(n_c), 32'd10);
    @(posedge clk); #1;
    c_req = 1'b0; l_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 4: L served once then idle; C keeps being served; L re-asserts and is served promptly
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    xfer(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, rd, er, ws, lat);
    n_c = 0; n_l = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (c_ack) n_c++;
      if (l_ack) n_l++;
    end
    chk("t4_c_acks", 32'(n_c), 32'd4);
    chk("t4_l_acks", 32'(n_l), 32'd0);
    @(posedge clk); #1;
    l_req = 1'b1; l_addr = 32'h4;
    got = 1'b0; waitc = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      if (l_ack) begin got = 1'b1; waitc = i; end
    end
    chk("t4_l_served", 32'(got), 32'd1);
    chk("t4_l_wait_ok", 32'(waitc <= 5), 32'd1);
    @(posedge clk); #1;
    l_req = 1'b0; c_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 6: reset asserted during the SERVE_C cycle of a write
    xfer(1'b0, 1'b1, 32'h40, 32'hAAAA5555, 32'h200, rd, er, ws, lat);
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h40; c_wdata = 32'h0BADF00D; c_pc = 32'h204;
    @(negedge clk);
    chk("t6_idle_ack", 32'(c_ack), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_ack", 32'(c_ack), 32'd0);
    chk("t6_rst_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; c_req = 1'b0;
    @(negedge clk);
    chk("t6_after_ack", 32'(c_ack), 32'd0);
    chk("t6_dm", dm[16], 32'hAAAA5555);
    @(posedge clk); #1;

    // Randomized traffic, with an occasional one-cycle reset
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst_n = (cyc % 300 != 150);
      if (c_req && m_c_acked) begin
        if ($urandom % 4 != 0) begin
          c_we = 1'($urandom); c_addr = rand_addr(); c_wdata = $urandom; c_pc = $urandom;
        end else c_req = 1'b0;
      end else if (c_req && ($urandom % 16 == 0)) begin
        c_req = 1'b0;
      end else if (!c_req && ($urandom % 3 == 0)) begin
        c_req = 1'b1; c_we = 1'($urandom); c_addr = rand_addr(); c_wdata = $urandom; c_pc = $urandom;
      end
      if (l_req && m_l_acked) begin
        if ($urandom % 4 != 0) begin
          l_we = 1'($urandom); l_addr = rand_addr(); l_wdata = $urandom;
        end else l_req = 1'b0;
      end else if (l_req && ($urandom % 16 == 0)) begin
        l_req = 1'b0;
      end else if (!l_req && ($urandom % 3 == 0)) begin
        l_req = 1'b1; l_we = 1'($urandom); l_addr = rand_addr(); l_wdata = $urandom;
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1; c_req = 1'b0; l_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
